// File: rtl/val2_shift_seq_if.sv
// Purpose: request/result bundle between the decode stage and the val2 shifter.
// Latency: wires only, no state.
// Backpressure: none in the bundle itself; busy is the stall back to the pipeline.
interface val2_shift_seq_if;
   logic        start;
   logic        flush;
   logic        imm;
   logic        mem_cmd;
   logic [11:0] shift_operand;
   logic [31:0] rm;
   logic [31:0] val2;
   logic        valid;
   logic        busy;

   modport master (
      output start, flush, imm, mem_cmd, shift_operand, rm,
      input  val2, valid, busy
   );

   modport slave (
      input  start, flush, imm, mem_cmd, shift_operand, rm,
      output val2, valid, busy
   );
endinterface

// File: rtl/val2_shift_seq.sv
// Purpose: builds the ARM second ALU operand with a 1-bit-per-cycle shifter.
// Latency: valid N+1 cycles after the start edge (N = decoded shift amount).
// Backpressure: busy stalls EXE; start is ignored while busy, flush aborts.
module val2_shift_seq (
   input logic              clk,
   input logic              rst,
   val2_shift_seq_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Mode codes line up with shift_operand[6:5]. OFS never steps, so it
   // shares the LSL code; ROT_IMM steps exactly like ROR, so it shares ROR.
   localparam logic [1:0] MODE_OFS     = 2'b00;
   localparam logic [1:0] MODE_LSL     = 2'b00;
   localparam logic [1:0] MODE_LSR     = 2'b01;
   localparam logic [1:0] MODE_ASR     = 2'b10;
   localparam logic [1:0] MODE_ROT_IMM = 2'b11;

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [1:0]  mode_q, mode_d;
   logic [31:0] val2_q, val2_d;
   logic [31:0] step_val;

   // One 1-bit step of the latched mode applied to the current value.
   always_comb begin
      step_val = {val2_q[0], val2_q[31:1]};
      case (mode_q)
         MODE_LSL: step_val = {val2_q[30:0], 1'b0};
         MODE_LSR: step_val = {1'b0, val2_q[31:1]};
         MODE_ASR: step_val = {val2_q[31], val2_q[31:1]};
         default:  step_val = {val2_q[0], val2_q[31:1]};
      endcase
   end

   // Next-state, capture and step logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      val2_d  = val2_q;
      case (state_q)
         IDLE: begin
            if (bus.start && !bus.flush) begin
               if (bus.mem_cmd) begin
                  val2_d = {{20{bus.shift_operand[11]}}, bus.shift_operand};
                  mode_d = MODE_OFS;
                  cnt_d  = 5'd0;
               end else if (bus.imm) begin
                  val2_d = {24'b0, bus.shift_operand[7:0]};
                  mode_d = MODE_ROT_IMM;
                  cnt_d  = {bus.shift_operand[11:8], 1'b0};
               end else begin
                  val2_d = bus.rm;
                  mode_d = bus.shift_operand[6:5];
                  cnt_d  = bus.shift_operand[11:7];
               end
               state_d = (cnt_d == 5'd0) ? DONE : SHIFT;
            end
         end
         SHIFT: begin
            if (bus.flush) begin
               // Abort: keep the partial value, drop the result.
               state_d = IDLE;
            end else begin
               val2_d = step_val;
               cnt_d  = cnt_q - 5'd1;
               if (cnt_q == 5'd1) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset clears everything immediately.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= 5'd0;
         mode_q  <= MODE_OFS;
         val2_q  <= 32'h0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         val2_q  <= val2_d;
      end
   end

   assign bus.val2  = val2_q;
   assign bus.valid = (state_q == DONE);
   assign bus.busy  = (state_q != IDLE);

endmodule

// File: tb/tb_val2_shift_seq.sv
module tb_val2_shift_seq;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   int   cyc;

   val2_shift_seq_if bus ();

   val2_shift_seq dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard: expected result value and the cycle its valid must appear in.
   logic [31:0] exp_val_q[$];
   int          exp_cyc_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: the whole ARM operand rule in one shot, no stepping.
   function automatic logic [31:0] model(input logic m, input logic im,
                                         input logic [11:0] so, input logic [31:0] r);
      logic [63:0] d;
      logic [31:0] res;
      int          n;
      if (m) begin
         res = {{20{so[11]}}, so};
      end else if (im) begin
         n   = 2 * int'(so[11:8]);
         d   = {24'b0, so[7:0], 24'b0, so[7:0]} >> n;
         res = d[31:0];
      end else begin
         n = int'(so[11:7]);
         case (so[6:5])
            2'b00:   res = r << n;
            2'b01:   res = r >> n;
            2'b10:   res = $signed(r) >>> n;
            default: begin
               d   = {r, r} >> n;
               res = d[31:0];
            end
         endcase
      end
      return res;
   endfunction

   function automatic int steps(input logic m, input logic im, input logic [11:0] so);
      if (m) return 0;
      if (im) return 2 * int'(so[11:8]);
      return int'(so[11:7]);
   endfunction

   // Monitor: every valid must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst && bus.valid) begin
         if (exp_val_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid: got val2 %h with no request pending (cycle %0d)",
                     bus.val2, cyc);
         end else begin
            check("val2", bus.val2, exp_val_q.pop_front());
            check("valid_cycle", cyc, exp_cyc_q.pop_front());
         end
      end
   end

   task automatic wait_idle();
      int b;
      b = 0;
      while (bus.busy && b < 50) begin
         @(posedge clk); #1;
         b++;
      end
      if (bus.busy) check("idle_wait", 32'(bus.busy), 32'd0);
   endtask

   task automatic randomize_operands();
      bus.imm           = 1'($urandom);
      bus.mem_cmd       = 1'($urandom);
      bus.shift_operand = 12'($urandom);
      bus.rm            = $urandom;
   endtask

   // Issue one request; flush_at>0 flushes in that busy cycle, extra pulses
   // a second start mid-shift. Also checks how many cycles busy stays high.
   task automatic issue(input logic m, input logic im, input logic [11:0] so,
                        input logic [31:0] r, input int flush_at, input bit extra);
      int n;
      int b;
      int k;
      wait_idle();
      n = steps(m, im, so);
      bus.mem_cmd       = m;
      bus.imm           = im;
      bus.shift_operand = so;
      bus.rm            = r;
      bus.start         = 1'b1;
      bus.flush         = 1'b0;
      k = cyc;
      if (flush_at == 0) begin
         exp_val_q.push_back(model(m, im, so, r));
         exp_cyc_q.push_back(k + 1 + n);
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      randomize_operands();
      b = 0;
      while (bus.busy && b < 40) begin
         b++;
         bus.start = (extra && b == 3);
         bus.flush = (flush_at != 0 && b == flush_at);
         @(posedge clk); #1;
      end
      bus.start = 1'b0;
      bus.flush = 1'b0;
      check("busy_len", 32'(b), (flush_at != 0) ? 32'(flush_at) : 32'(n + 1));
   endtask

   initial begin
      logic [31:0] held;
      checks = 0;
      errors = 0;
      cyc    = 0;
      bus.start = 1'b0;
      bus.flush = 1'b0;
      bus.imm = 1'b0;
      bus.mem_cmd = 1'b0;
      bus.shift_operand = 12'h0;
      bus.rm = 32'h0;
      rst = 1'b0;
      #1;
      check("rst_val2", bus.val2, 32'h0);
      check("rst_valid", 32'(bus.valid), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;

      // Spec vectors, with the held val2 compared to the literal result.
      issue(1'b1, 1'b0, 12'hFFC, 32'h12345678, 0, 1'b0);
      check("mem_ffc", bus.val2, 32'hFFFFFFFC);
      issue(1'b0, 1'b1, 12'h4FF, 32'h0, 0, 1'b0);
      check("imm_4ff", bus.val2, 32'hFF000000);
      issue(1'b0, 1'b0, 12'h240, 32'h80000000, 0, 1'b0);
      check("asr4", bus.val2, 32'hF8000000);
      issue(1'b0, 1'b0, 12'h220, 32'h80000000, 0, 1'b0);
      check("lsr4", bus.val2, 32'h08000000);
      issue(1'b0, 1'b0, 12'hFE0, 32'h00000001, 0, 1'b1);
      check("ror31", bus.val2, 32'h00000002);

      // Flush at shift step 3 of LSL 8: two steps applied, result dropped.
      issue(1'b0, 1'b0, 12'h400, 32'h000000FF, 3, 1'b0);
      check("flush_busy", 32'(bus.busy), 32'd0);
      check("flush_partial", bus.val2, 32'h000003FC);
      issue(1'b0, 1'b0, 12'h400, 32'h000000FF, 0, 1'b0);
      check("after_flush", bus.val2, 32'h0000FF00);

      // Flush in IDLE blocks capture.
      held = bus.val2;
      bus.start = 1'b1;
      bus.flush = 1'b1;
      bus.rm    = 32'hDEADBEEF;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.flush = 1'b0;
      check("idle_flush_busy", 32'(bus.busy), 32'd0);
      check("idle_flush_hold", bus.val2, held);

      // Zero shift amounts in every form.
      issue(1'b0, 1'b0, 12'h020, 32'h80000001, 0, 1'b0);
      issue(1'b0, 1'b0, 12'h040, 32'h80000001, 0, 1'b0);
      issue(1'b0, 1'b0, 12'h060, 32'h80000001, 0, 1'b0);
      issue(1'b0, 1'b1, 12'h0A5, 32'h0, 0, 1'b0);

      // Asynchronous reset mid-shift.
      wait_idle();
      bus.mem_cmd = 1'b0;
      bus.imm = 1'b0;
      bus.shift_operand = 12'hFE0;
      bus.rm = 32'hA5A5A5A5;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (5) @(posedge clk);
      #1 rst = 1'b0;
      exp_val_q.delete();
      exp_cyc_q.delete();
      #1;
      check("midrst_val2", bus.val2, 32'h0);
      check("midrst_valid", 32'(bus.valid), 32'd0);
      check("midrst_busy", 32'(bus.busy), 32'd0);
      @(posedge clk); #1 rst = 1'b1;
      issue(1'b0, 1'b0, 12'h1E0, 32'h0000F00F, 0, 1'b0);

      // Randomized requests against the reference model.
      for (int i = 0; i < 60; i++) begin
         issue(1'($urandom_range(0, 3) == 0), 1'($urandom), 12'($urandom), $urandom, 0, 1'b0);
      end

      repeat (3) @(posedge clk);
      #1;
      check("pending_left", 32'(exp_val_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish, checks %0d errors %0d", checks, errors);
      $fatal(1);
   end

endmodule
